md_sequencer: RTL

MD_SEQUENCER -- requirements
Module: md_sequencer

---
 rtl/md_sequencer_pkg.sv | 28 ++
 rtl/md_sequencer_if.sv | 17 +
 rtl/md_sequencer_arith.sv | 48 ++++
 rtl/md_sequencer.sv | 90 +++++++++
 4 files changed

// File: rtl/md_sequencer_pkg.sv
// Shared op codes, default latencies and result type for the mult/div sequencer.
package md_sequencer_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;

    localparam int unsigned MULT_CYC_DEF = 5;
    localparam int unsigned DIV_CYC_DEF  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_res_t;

    function automatic logic is_arith_op(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_mult_op(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// E-stage op/operand bundle into the mult/div sequencer and its status/HI/LO back.
interface md_sequencer_if;
    import md_sequencer_pkg::*;

    logic [3:0]  md_op;
    logic [31:0] rs_e;
    logic [31:0] rt_e;
    logic        Req;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output md_op, rs_e, rt_e, Req, input start, busy, hi, lo);
    modport slave  (input md_op, rs_e, rt_e, Req, output start, busy, hi, lo);

endinterface

// File: rtl/md_sequencer_arith.sv
// Combinational 64-bit result for mult/multu/div/divu; div_zero flags a zero divisor.
module md_arith
    import md_sequencer_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output md_res_t     res,
    output logic        div_zero
);

    logic signed [63:0] sprod;
    logic        [63:0] uprod;

    assign sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign uprod = {32'd0, a} * {32'd0, b};

    always_comb begin
        res      = '0;
        div_zero = 1'b0;
        case (op)
            MD_MULT:  res = md_res_t'(sprod);
            MD_MULTU: res = md_res_t'(uprod);
            MD_DIV: begin
                if (b == 32'd0) begin
                    div_zero = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    // Overflow case: quotient wraps to the dividend, remainder zero.
                    res.lo = a;
                    res.hi = 32'd0;
                end else begin
                    res.lo = $signed(a) / $signed(b);
                    res.hi = $signed(a) % $signed(b);
                end
            end
            MD_DIVU: begin
                if (b == 32'd0) begin
                    div_zero = 1'b1;
                end else begin
                    res.lo = a / b;
                    res.hi = a % b;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle HI/LO sequencer: result computed at accept, published after MULT_CYC/DIV_CYC busy cycles.
// Ops arriving while busy or flushed by Req are dropped; upstream must stall and hold them.
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int unsigned MULT_CYC = MULT_CYC_DEF,
    parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
    input  logic           clk,
    input  logic           reset,
    md_sequencer_if.slave  md
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]  state;
    logic [3:0]  cnt;
    logic        busy_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] temp_hi;
    logic [31:0] temp_lo;

    md_res_t     arith_res;
    logic        div_zero;
    logic        start;
    logic        can_move;

    md_arith u_arith (
        .op       (md.md_op),
        .a        (md.rs_e),
        .b        (md.rt_e),
        .res      (arith_res),
        .div_zero (div_zero)
    );

    assign can_move = ~busy_q & ~md.Req & ~reset;
    assign start    = is_arith_op(md.md_op) & can_move;

    assign md.start = start;
    assign md.busy  = busy_q;
    assign md.hi    = hi_q;
    assign md.lo    = lo_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            temp_hi <= 32'd0;
            temp_lo <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // A zero divisor commits the current HI/LO, leaving them unchanged.
                        temp_hi <= div_zero ? hi_q : arith_res.hi;
                        temp_lo <= div_zero ? lo_q : arith_res.lo;
                        cnt     <= is_mult_op(md.md_op) ? 4'(MULT_CYC) : 4'(DIV_CYC);
                        busy_q  <= 1'b1;
                        state   <= S_RUN;
                    end else if (can_move && md.md_op == MD_MTHI) begin
                        hi_q <= md.rs_e;
                    end else if (can_move && md.md_op == MD_MTLO) begin
                        lo_q <= md.rs_e;
                    end
                end
                S_RUN: begin
                    if (cnt == 4'd1) begin
                        hi_q   <= temp_hi;
                        lo_q   <= temp_lo;
                        busy_q <= 1'b0;
                        cnt    <= 4'd0;
                        state  <= S_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
